srpt_grant_receiver: RTL and testbench
======================================

Name: srpt_grant_receiver

Overview:
- Sender-side counterpart of the grant queue. It consumes grant packets returned by the peer, keeps a per-RPC granted-byte limit, and emits data-packet requests only up to the granted limit.
- Sits between the sendmsg path (message registration) and the packet-builder FIFO.
- Interfaces are FIFO-style: empty/read_en/data on inputs, full/write_en/data on the output.

Parameters:
- NUM_RPCS, 16, table entries; rpc_id is indexed modulo NUM_RPCS (low log2 bits).
- MTU, 1024, maximum payload bytes per emitted data packet.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  synchronous active-low reset
- sendmsg_in_empty_i  in  1  sendmsg FIFO empty
- sendmsg_in_read_en_o  out  1  sendmsg FIFO pop
- sendmsg_in_data_i  in  78  [77:64] rpc_id, [63:32] message_length, [31:0] unscheduled bytes
- grant_in_empty_i  in  1  grant FIFO empty
- grant_in_read_en_o  out  1  grant FIFO pop
- grant_in_data_i  in  95  [94:81] peer_id, [80:67] rpc_id, [66:64] priority, [63:32] grant_offset, [31:0] reserved
- data_pkt_full_i  in  1  output FIFO full
- data_pkt_write_en_o  out  1  output push
- data_pkt_data_o  out  78  [77:64] rpc_id, [63:32] byte offset, [31:0] payload length
- err_o  out  1  one-cycle pulse on a dropped event

Behaviour:
- Reset (ap_rst_n=0 at an ap_clk edge):
  - All entries go invalid; scan pointer goes to 0.
  - read_en outputs, data_pkt_write_en_o and err_o go to 0; data_pkt_data_o goes to 0.
  - Any in-flight event is discarded.
- Entry fields: valid, msg_len[31:0], sent[31:0], granted[31:0].
- Input arbitration, one event per cycle:
  - Sendmsg has priority over grant.
  - A read_en output is combinational and asserted only when its FIFO is non-empty and it wins arbitration.
  - The FIFO is first-word-fall-through: data is valid while empty=0 and is consumed at the edge where read_en=1.
  - The table update lands at that same edge.
- Sendmsg event:
  - If the entry is invalid: write valid=1, msg_len=length, sent=0, granted=min(unscheduled, length).
  - If the entry is already valid: drop the event and pulse err_o next cycle.
- Grant event:
  - If the entry is invalid: drop the event and pulse err_o.
  - Otherwise: granted = max(granted, min(grant_offset, msg_len)). Grants never decrease the limit. peer_id and priority are ignored.
- Emission stage:
  - Each cycle the scan pointer examines one entry.
  - An entry is eligible when valid && granted > sent && !data_pkt_full_i.
  - When eligible:
    - Register the output: rpc_id = pointer, offset = sent, length = min(MTU, granted-sent).
    - Drive write_en=1 for exactly one cycle.
    - Update sent += length.
    - If the new sent equals msg_len, clear valid in the same edge.
  - The pointer advances by 1 every cycle (wrap NUM_RPCS-1 to 0) whether or not the entry emitted, giving round-robin fairness.
  - If the pointed entry is eligible but full=1: write_en=0, no state change, and the pointer holds until full drops. This is the only stall.
- Latency:
  - A grant popped at edge N makes its entry eligible at the emission stage from cycle N+1.
  - Earliest write_en is at edge N+1 if the pointer is on that entry.
- Simultaneous events on the same entry in one cycle:
  - A grant updates granted while the emission reads the old granted and updates sent. Both writes apply; the fields are disjoint.
  - If the emission completes the message (clears valid), a simultaneous grant to it is dropped silently (no err_o).
  - A sendmsg to an entry being completed that cycle is treated as a write to a valid entry: it is dropped and err_o pulses.
- Arithmetic: all offsets are unsigned 32-bit; granted ≤ msg_len always, so granted-sent never underflows.
- Zero-length sendmsg: accepted as valid with granted=0, then cleared on its first scan with no emission.

Decomposition:
- Shared package srpt_pkg holds:
  - field width constants: RPC_ID_W=14, OFFSET_W=32;
  - bit-slice localparams for the sendmsg, grant and data_pkt formats, shared with srpt_grant_queue;
  - the entry struct typedef.
- One natural sub-module: srpt_rpc_table. It is a NUM_RPCS-entry register file with one event write port and one emission read-modify-write port, and it implements the collision rules above. The top level holds arbitration, the scan pointer and output registers.

Test Plan:
1. Reset then idle:
   - Stimulus: drive ap_rst_n=0 for 2 cycles, all FIFOs empty.
   - Required: all outputs 0 and no write_en for 50 cycles.
2. Unscheduled only:
   - Stimulus: sendmsg rpc=1, length=3000, unsched=1500.
   - Required: exactly two packets (1,0,1024) and (1,1024,476), then silence.
3. Grant release:
   - Stimulus: continue scenario 2 with grant rpc=1 offset=3000.
   - Required: (1,1500,1024) and (1,2524,476), then entry 1 invalid; a further grant to rpc 1 pulses err_o.
4. Monotonic/clamp:
   - Stimulus: sendmsg rpc=2, length=0x10000, unsched=0; grant offset=0xFFFFFFFF, then grant offset=4.
   - Required: granted clamps to 0x10000, the second grant is ignored, and 64 packets of 1024 are emitted.
5. Backpressure:
   - Stimulus: hold data_pkt_full_i=1 while entries 3 and 4 are eligible.
   - Required: no write_en and the pointer holds; after release, entry 3 emits before entry 4 with no lost or duplicated offsets.
6. Arbitration/collision:
   - Stimulus: sendmsg and grant non-empty in the same cycle.
   - Required: sendmsg popped first and grant the next cycle; a sendmsg to a valid rpc pulses err_o and leaves the table unchanged.

Source files
------------

// File: rtl/srpt_pkg.sv
// Shared field widths, packet bit-slices and the per-RPC entry type for the SRPT
// grant queue / grant receiver pair.
package srpt_pkg;

    localparam int RPC_ID_W = 14;
    localparam int OFFSET_W = 32;

    // sendmsg: {rpc_id, message_length, unscheduled_bytes}
    localparam int SENDMSG_W     = 78;
    localparam int SM_RPC_HI     = 77;
    localparam int SM_RPC_LO     = 64;
    localparam int SM_LEN_HI     = 63;
    localparam int SM_LEN_LO     = 32;
    localparam int SM_UNSCHED_HI = 31;
    localparam int SM_UNSCHED_LO = 0;

    // grant: {peer_id, rpc_id, priority, grant_offset, reserved}
    localparam int GRANT_W      = 95;
    localparam int GR_PEER_HI   = 94;
    localparam int GR_PEER_LO   = 81;
    localparam int GR_RPC_HI    = 80;
    localparam int GR_RPC_LO    = 67;
    localparam int GR_PRIO_HI   = 66;
    localparam int GR_PRIO_LO   = 64;
    localparam int GR_OFFSET_HI = 63;
    localparam int GR_OFFSET_LO = 32;
    localparam int GR_RSVD_HI   = 31;
    localparam int GR_RSVD_LO   = 0;

    // data packet request: {rpc_id, byte_offset, payload_length}
    localparam int DATA_PKT_W   = 78;
    localparam int DP_RPC_HI    = 77;
    localparam int DP_RPC_LO    = 64;
    localparam int DP_OFFSET_HI = 63;
    localparam int DP_OFFSET_LO = 32;
    localparam int DP_LEN_HI    = 31;
    localparam int DP_LEN_LO    = 0;

    typedef struct packed {
        logic                valid;
        logic [OFFSET_W-1:0] msg_len;
        logic [OFFSET_W-1:0] sent;
        logic [OFFSET_W-1:0] granted;
    } rpc_entry_t;

    function automatic logic [OFFSET_W-1:0] min_off(input logic [OFFSET_W-1:0] a,
                                                    input logic [OFFSET_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [OFFSET_W-1:0] max_off(input logic [OFFSET_W-1:0] a,
                                                    input logic [OFFSET_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/srpt_rpc_table.sv
// Per-RPC send-state table: one event write port (sendmsg / grant) and one
// emission read-modify-write port driven by the scan pointer.
module srpt_rpc_table
    import srpt_pkg::*;
#(
    parameter int NUM_RPCS = 16,
    parameter int IDX_W    = $clog2(NUM_RPCS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ev_sendmsg,
    input  logic                ev_grant,
    input  logic [IDX_W-1:0]    ev_idx,
    input  logic [OFFSET_W-1:0] ev_len,
    input  logic [OFFSET_W-1:0] ev_unsched,
    input  logic [OFFSET_W-1:0] ev_offset,
    output logic                ev_drop,
    input  logic [IDX_W-1:0]    scan_idx,
    input  logic [OFFSET_W-1:0] scan_len,
    output logic                scan_valid,
    output logic [OFFSET_W-1:0] scan_sent,
    output logic [OFFSET_W-1:0] scan_granted
);

    rpc_entry_t entries_q   [NUM_RPCS];
    rpc_entry_t entries_nxt [NUM_RPCS];
    logic [OFFSET_W-1:0] sent_new;

    assign scan_valid   = entries_q[scan_idx].valid;
    assign scan_sent    = entries_q[scan_idx].sent;
    assign scan_granted = entries_q[scan_idx].granted;
    assign sent_new     = entries_q[scan_idx].sent + scan_len;

    // Both ports judge validity on the pre-edge state, so a sendmsg only writes
    // invalid entries and the scan only writes valid ones; a grant and the scan
    // touch disjoint fields and may land together.
    always_comb begin
        entries_nxt = entries_q;
        ev_drop     = 1'b0;
        if (ev_sendmsg) begin
            if (entries_q[ev_idx].valid) begin
                ev_drop = 1'b1;
            end else begin
                entries_nxt[ev_idx].valid   = 1'b1;
                entries_nxt[ev_idx].msg_len = ev_len;
                entries_nxt[ev_idx].sent    = '0;
                entries_nxt[ev_idx].granted = min_off(ev_unsched, ev_len);
            end
        end else if (ev_grant) begin
            if (!entries_q[ev_idx].valid) begin
                ev_drop = 1'b1;
            end else begin
                entries_nxt[ev_idx].granted =
                    max_off(entries_q[ev_idx].granted,
                            min_off(ev_offset, entries_q[ev_idx].msg_len));
            end
        end

        // Completion (including zero-length messages) retires the entry; a grant
        // landing on it this cycle is lost with the entry.
        if (entries_q[scan_idx].valid) begin
            entries_nxt[scan_idx].sent = sent_new;
            if (sent_new == entries_q[scan_idx].msg_len) begin
                entries_nxt[scan_idx].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RPCS; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RPCS; i++) begin
                entries_q[i] <= entries_nxt[i];
            end
        end
    end

endmodule

// File: rtl/srpt_grant_receiver.sv
// Sender-side grant receiver: registers messages, absorbs peer grants and emits
// MTU-sized data-packet requests up to each RPC's granted limit, round-robin.
module srpt_grant_receiver
    import srpt_pkg::*;
#(
    parameter int NUM_RPCS = 16,
    parameter int MTU      = 1024
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  sendmsg_in_empty_i,
    output logic                  sendmsg_in_read_en_o,
    input  logic [SENDMSG_W-1:0]  sendmsg_in_data_i,
    input  logic                  grant_in_empty_i,
    output logic                  grant_in_read_en_o,
    input  logic [GRANT_W-1:0]    grant_in_data_i,
    input  logic                  data_pkt_full_i,
    output logic                  data_pkt_write_en_o,
    output logic [DATA_PKT_W-1:0] data_pkt_data_o,
    output logic                  err_o
);

    localparam int IDX_W = $clog2(NUM_RPCS);
    localparam logic [OFFSET_W-1:0] MTU_BYTES = OFFSET_W'(MTU);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_RPCS - 1);

    logic                sm_pop;
    logic                gr_pop;
    logic [IDX_W-1:0]    ev_idx;
    logic                ev_drop;
    logic [IDX_W-1:0]    ptr_q;
    logic                scan_valid;
    logic [OFFSET_W-1:0] scan_sent;
    logic [OFFSET_W-1:0] scan_granted;
    logic                has_credit;
    logic                emit;
    logic                stall;
    logic [OFFSET_W-1:0] emit_len;
    logic                unused_fields;

    // sendmsg always wins; a pending grant waits for an idle sendmsg cycle.
    assign sm_pop = ap_rst_n && !sendmsg_in_empty_i;
    assign gr_pop = ap_rst_n && !grant_in_empty_i && sendmsg_in_empty_i;

    assign sendmsg_in_read_en_o = sm_pop;
    assign grant_in_read_en_o   = gr_pop;

    assign ev_idx = sm_pop ? sendmsg_in_data_i[SM_RPC_LO +: IDX_W]
                           : grant_in_data_i[GR_RPC_LO +: IDX_W];

    assign unused_fields = ^{sendmsg_in_data_i[SM_RPC_HI:SM_RPC_LO+IDX_W],
                             grant_in_data_i[GR_PEER_HI:GR_PEER_LO],
                             grant_in_data_i[GR_RPC_HI:GR_RPC_LO+IDX_W],
                             grant_in_data_i[GR_PRIO_HI:GR_PRIO_LO],
                             grant_in_data_i[GR_RSVD_HI:GR_RSVD_LO]};

    srpt_rpc_table #(
        .NUM_RPCS (NUM_RPCS),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk          (ap_clk),
        .rst_n        (ap_rst_n),
        .ev_sendmsg   (sm_pop),
        .ev_grant     (gr_pop),
        .ev_idx       (ev_idx),
        .ev_len       (sendmsg_in_data_i[SM_LEN_HI:SM_LEN_LO]),
        .ev_unsched   (sendmsg_in_data_i[SM_UNSCHED_HI:SM_UNSCHED_LO]),
        .ev_offset    (grant_in_data_i[GR_OFFSET_HI:GR_OFFSET_LO]),
        .ev_drop      (ev_drop),
        .scan_idx     (ptr_q),
        .scan_len     (emit_len),
        .scan_valid   (scan_valid),
        .scan_sent    (scan_sent),
        .scan_granted (scan_granted)
    );

    // Only an entry that has credit but meets a full FIFO holds the pointer.
    assign has_credit = scan_valid && (scan_granted > scan_sent);
    assign emit       = has_credit && !data_pkt_full_i;
    assign stall      = has_credit && data_pkt_full_i;
    assign emit_len   = emit ? min_off(MTU_BYTES, scan_granted - scan_sent) : '0;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ptr_q               <= '0;
            data_pkt_write_en_o <= 1'b0;
            data_pkt_data_o     <= '0;
            err_o               <= 1'b0;
        end else begin
            data_pkt_write_en_o <= emit;
            err_o               <= ev_drop;
            if (emit) begin
                data_pkt_data_o <= {RPC_ID_W'(ptr_q), scan_sent, emit_len};
            end
            if (!stall) begin
                ptr_q <= (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_srpt_grant_receiver.sv
// Self-checking bench for srpt_grant_receiver: directed scenarios plus a
// randomized event stream checked against a per-RPC byte-accounting model.
`timescale 1ns/1ps
module tb_srpt_grant_receiver;

    typedef struct {
        logic [13:0] rpc;
        logic [31:0] off;
        logic [31:0] len;
        int          cyc;
    } pkt_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        sendmsg_in_empty_i;
    logic        sendmsg_in_read_en_o;
    logic [77:0] sendmsg_in_data_i;
    logic        grant_in_empty_i;
    logic        grant_in_read_en_o;
    logic [94:0] grant_in_data_i;
    logic        data_pkt_full_i;
    logic        data_pkt_write_en_o;
    logic [77:0] data_pkt_data_o;
    logic        err_o;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   err_cnt = 0;
    pkt_t pkt_q[$];
    pkt_t exp_q[$];

    always #5 ap_clk = ~ap_clk;

    srpt_grant_receiver #(.NUM_RPCS(16), .MTU(1024)) dut (
        .ap_clk               (ap_clk),
        .ap_rst_n             (ap_rst_n),
        .sendmsg_in_empty_i   (sendmsg_in_empty_i),
        .sendmsg_in_read_en_o (sendmsg_in_read_en_o),
        .sendmsg_in_data_i    (sendmsg_in_data_i),
        .grant_in_empty_i     (grant_in_empty_i),
        .grant_in_read_en_o   (grant_in_read_en_o),
        .grant_in_data_i      (grant_in_data_i),
        .data_pkt_full_i      (data_pkt_full_i),
        .data_pkt_write_en_o  (data_pkt_write_en_o),
        .data_pkt_data_o      (data_pkt_data_o),
        .err_o                (err_o)
    );

    always @(posedge ap_clk) cyc++;

    always @(negedge ap_clk) begin
        pkt_t p;
        if (data_pkt_write_en_o === 1'b1) begin
            p.rpc = data_pkt_data_o[77:64];
            p.off = data_pkt_data_o[63:32];
            p.len = data_pkt_data_o[31:0];
            p.cyc = cyc;
            pkt_q.push_back(p);
        end
        if (err_o === 1'b1) err_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: the bytes [s, g) of one RPC leave as MTU chunks in order.
    function automatic void add_chunks(input logic [13:0] rpc, input logic [31:0] s,
                                       input logic [31:0] g);
        pkt_t p;
        logic [31:0] cur;
        cur = s;
        while (cur < g) begin
            p.rpc = rpc;
            p.off = cur;
            p.len = (g - cur > 32'd1024) ? 32'd1024 : g - cur;
            p.cyc = 0;
            exp_q.push_back(p);
            cur   = cur + p.len;
        end
    endfunction

    task automatic do_reset();
        ap_rst_n           = 1'b0;
        sendmsg_in_empty_i = 1'b1;
        grant_in_empty_i   = 1'b1;
        sendmsg_in_data_i  = '0;
        grant_in_data_i    = '0;
        data_pkt_full_i    = 1'b0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic push_sendmsg(input logic [13:0] rpc, input logic [31:0] len,
                                input logic [31:0] uns);
        @(negedge ap_clk);
        sendmsg_in_data_i  = {rpc, len, uns};
        sendmsg_in_empty_i = 1'b0;
        #1;
        n_cmp++;
        if (sendmsg_in_read_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sendmsg_pop: read_en=%b want 1", sendmsg_in_read_en_o);
        end
        @(posedge ap_clk);
        #1 sendmsg_in_empty_i = 1'b1;
    endtask

    task automatic push_grant(input logic [13:0] rpc, input logic [31:0] off);
        @(negedge ap_clk);
        grant_in_data_i  = {14'($urandom), rpc, 3'($urandom), off, 32'($urandom)};
        grant_in_empty_i = 1'b0;
        #1;
        n_cmp++;
        if (grant_in_read_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_pop: read_en=%b want 1", grant_in_read_en_o);
        end
        @(posedge ap_clk);
        #1 grant_in_empty_i = 1'b1;
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n;
        n = 0;
        while (pkt_q.size() < target && n < budget) begin
            @(posedge ap_clk);
            n++;
        end
        repeat (20) @(posedge ap_clk);
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        #1;
        n_cmp++;
        if ({data_pkt_write_en_o, err_o, sendmsg_in_read_en_o, grant_in_read_en_o} !== 4'b0
            || data_pkt_data_o !== 78'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b err=%b rd=%b%b data=%h want all 0",
                     data_pkt_write_en_o, err_o, sendmsg_in_read_en_o,
                     grant_in_read_en_o, data_pkt_data_o);
        end
        bad = 0;
        repeat (50) begin
            @(negedge ap_clk);
            if (data_pkt_write_en_o !== 1'b0 || err_o !== 1'b0 || data_pkt_data_o !== 78'd0
                || sendmsg_in_read_en_o !== 1'b0 || grant_in_read_en_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || pkt_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle: %0d nonzero cycles, %0d packets, want 0/0",
                     bad, pkt_q.size());
        end
    endtask

    task automatic test_unscheduled();
        int base, ebase;
        base = pkt_q.size(); ebase = err_cnt;
        exp_q.delete();
        push_sendmsg(14'd1, 32'd3000, 32'd1500);
        add_chunks(14'd1, 32'd0, 32'd1500);
        wait_pkts(base + exp_q.size(), 100);
        n_cmp++;
        if (pkt_q.size() - base != exp_q.size() || err_cnt != ebase) begin
            n_fail++;
            $display("FAIL unsched_count: pkts=%0d err=%0d want pkts=%0d err=0",
                     pkt_q.size() - base, err_cnt - ebase, exp_q.size());
        end
        foreach (exp_q[i]) if (base + i < pkt_q.size()) begin
            n_cmp++;
            if (pkt_q[base+i].rpc !== exp_q[i].rpc || pkt_q[base+i].off !== exp_q[i].off
                || pkt_q[base+i].len !== exp_q[i].len) begin
                n_fail++;
                $display("FAIL unsched_pkt%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         pkt_q[base+i].rpc, pkt_q[base+i].off, pkt_q[base+i].len,
                         exp_q[i].rpc, exp_q[i].off, exp_q[i].len);
            end
        end
    endtask

    task automatic test_grant_release();
        int base, ebase;
        base = pkt_q.size(); ebase = err_cnt;
        exp_q.delete();
        push_grant(14'd1, 32'd3000);
        add_chunks(14'd1, 32'd1500, 32'd3000);
        wait_pkts(base + exp_q.size(), 100);
        foreach (exp_q[i]) if (base + i < pkt_q.size()) begin
            n_cmp++;
            if (pkt_q[base+i].rpc !== exp_q[i].rpc || pkt_q[base+i].off !== exp_q[i].off
                || pkt_q[base+i].len !== exp_q[i].len) begin
                n_fail++;
                $display("FAIL release_pkt%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         pkt_q[base+i].rpc, pkt_q[base+i].off, pkt_q[base+i].len,
                         exp_q[i].rpc, exp_q[i].off, exp_q[i].len);
            end
        end
        push_grant(14'd1, 32'd3000);
        repeat (20) @(posedge ap_clk);
        n_cmp++;
        if (pkt_q.size() - base != exp_q.size() || err_cnt - ebase != 1) begin
            n_fail++;
            $display("FAIL release_retired: pkts=%0d err=%0d want pkts=%0d err=1",
                     pkt_q.size() - base, err_cnt - ebase, exp_q.size());
        end
    endtask

    task automatic test_clamp();
        int base, ebase, bad;
        base = pkt_q.size(); ebase = err_cnt;
        exp_q.delete();
        push_sendmsg(14'd2, 32'h10000, 32'd0);
        push_grant(14'd2, 32'hFFFF_FFFF);
        push_grant(14'd2, 32'd4);
        add_chunks(14'd2, 32'd0, 32'h10000);
        wait_pkts(base + exp_q.size(), 64 * 16 + 100);
        n_cmp++;
        if (pkt_q.size() - base != 64 || err_cnt != ebase) begin
            n_fail++;
            $display("FAIL clamp_count: pkts=%0d err=%0d want pkts=64 err=0",
                     pkt_q.size() - base, err_cnt - ebase);
        end
        bad = 0;
        foreach (exp_q[i]) if (base + i < pkt_q.size()) begin
            if (pkt_q[base+i].rpc !== exp_q[i].rpc || pkt_q[base+i].off !== exp_q[i].off
                || pkt_q[base+i].len !== exp_q[i].len) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL clamp_pkts: %0d packets differ from 64x(2,i*1024,1024), want 0", bad);
        end
        push_grant(14'd2, 32'd100);
        repeat (20) @(posedge ap_clk);
        n_cmp++;
        if (err_cnt - ebase != 1 || pkt_q.size() - base != 64) begin
            n_fail++;
            $display("FAIL clamp_retired: err=%0d pkts=%0d want err=1 pkts=64",
                     err_cnt - ebase, pkt_q.size() - base);
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = pkt_q.size();
        exp_q.delete();
        @(negedge ap_clk);
        data_pkt_full_i = 1'b1;
        push_sendmsg(14'd3, 32'd2000, 32'd2000);
        repeat (20) @(posedge ap_clk);
        push_sendmsg(14'd4, 32'd100, 32'd100);
        repeat (40) @(posedge ap_clk);
        n_cmp++;
        if (pkt_q.size() != base) begin
            n_fail++;
            $display("FAIL bp_hold: %0d packets while full, want 0", pkt_q.size() - base);
        end
        @(negedge ap_clk);
        data_pkt_full_i = 1'b0;
        add_chunks(14'd3, 32'd0, 32'd1024);
        add_chunks(14'd4, 32'd0, 32'd100);
        add_chunks(14'd3, 32'd1024, 32'd2000);
        wait_pkts(base + 3, 100);
        n_cmp++;
        if (pkt_q.size() - base != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d packets want 3", pkt_q.size() - base);
        end
        foreach (exp_q[i]) if (base + i < pkt_q.size()) begin
            n_cmp++;
            if (pkt_q[base+i].rpc !== exp_q[i].rpc || pkt_q[base+i].off !== exp_q[i].off
                || pkt_q[base+i].len !== exp_q[i].len) begin
                n_fail++;
                $display("FAIL bp_pkt%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         pkt_q[base+i].rpc, pkt_q[base+i].off, pkt_q[base+i].len,
                         exp_q[i].rpc, exp_q[i].off, exp_q[i].len);
            end
        end
        if (pkt_q.size() - base >= 2) begin
            n_cmp++;
            if (pkt_q[base+1].cyc - pkt_q[base].cyc != 1) begin
                n_fail++;
                $display("FAIL bp_ptr_held: entry 4 emitted %0d cycles after entry 3, want 1",
                         pkt_q[base+1].cyc - pkt_q[base].cyc);
            end
        end
    endtask

    task automatic test_arbitration();
        int base, ebase;
        base = pkt_q.size(); ebase = err_cnt;
        exp_q.delete();
        @(negedge ap_clk);
        sendmsg_in_data_i  = {14'd5, 32'd10, 32'd0};
        grant_in_data_i    = {14'd0, 14'd5, 3'd0, 32'd10, 32'd0};
        sendmsg_in_empty_i = 1'b0;
        grant_in_empty_i   = 1'b0;
        #1;
        n_cmp++;
        if ({sendmsg_in_read_en_o, grant_in_read_en_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL arb_first: rd(sm,gr)=%b%b want 10",
                     sendmsg_in_read_en_o, grant_in_read_en_o);
        end
        @(posedge ap_clk);
        #1 sendmsg_in_empty_i = 1'b1;
        #1;
        n_cmp++;
        if ({sendmsg_in_read_en_o, grant_in_read_en_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL arb_second: rd(sm,gr)=%b%b want 01",
                     sendmsg_in_read_en_o, grant_in_read_en_o);
        end
        @(posedge ap_clk);
        #1 grant_in_empty_i = 1'b1;
        add_chunks(14'd5, 32'd0, 32'd10);
        wait_pkts(base + 1, 60);
        n_cmp++;
        if (pkt_q.size() - base != 1 || err_cnt != ebase) begin
            n_fail++;
            $display("FAIL arb_result: pkts=%0d err=%0d want pkts=1 err=0",
                     pkt_q.size() - base, err_cnt - ebase);
        end else if (pkt_q[base].rpc !== 14'd5 || pkt_q[base].off !== 32'd0
                     || pkt_q[base].len !== 32'd10) begin
            n_fail++;
            $display("FAIL arb_pkt: got (%0d,%0d,%0d) want (5,0,10)",
                     pkt_q[base].rpc, pkt_q[base].off, pkt_q[base].len);
        end

        base = pkt_q.size();
        exp_q.delete();
        push_sendmsg(14'd6, 32'd5000, 32'd0);
        push_sendmsg(14'd6, 32'd100, 32'd100);
        repeat (40) @(posedge ap_clk);
        n_cmp++;
        if (err_cnt - ebase != 1 || pkt_q.size() != base) begin
            n_fail++;
            $display("FAIL dup_sendmsg: err=%0d pkts=%0d want err=1 pkts=0",
                     err_cnt - ebase, pkt_q.size() - base);
        end
        push_grant(14'd6, 32'd5000);
        add_chunks(14'd6, 32'd0, 32'd5000);
        wait_pkts(base + exp_q.size(), 150);
        n_cmp++;
        if (pkt_q.size() - base != exp_q.size()) begin
            n_fail++;
            $display("FAIL dup_count: got %0d packets want %0d", pkt_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) if (base + i < pkt_q.size()) begin
            n_cmp++;
            if (pkt_q[base+i].rpc !== exp_q[i].rpc || pkt_q[base+i].off !== exp_q[i].off
                || pkt_q[base+i].len !== exp_q[i].len) begin
                n_fail++;
                $display("FAIL dup_pkt%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         pkt_q[base+i].rpc, pkt_q[base+i].off, pkt_q[base+i].len,
                         exp_q[i].rpc, exp_q[i].off, exp_q[i].len);
            end
        end
    endtask

    task automatic test_random();
        logic        m_valid [16];
        logic [31:0] m_len   [16];
        logic [31:0] m_sent  [16];
        logic [31:0] m_gr    [16];
        int          base, ebase, exp_err;
        logic [13:0] rpc;
        logic [31:0] len, uns, off, clip;
        int          idx;
        bit          is_sm;

        // State held across a reset must be forgotten.
        push_sendmsg(14'd7, 32'd100, 32'd0);
        repeat (5) @(posedge ap_clk);
        do_reset();
        ebase = err_cnt;
        push_grant(14'd7, 32'd100);
        repeat (30) @(posedge ap_clk);
        n_cmp++;
        if (err_cnt - ebase != 1) begin
            n_fail++;
            $display("FAIL reset_clears: err=%0d want 1 for grant after reset", err_cnt - ebase);
        end

        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_len[i] = '0; m_sent[i] = '0; m_gr[i] = '0;
        end
        for (int n = 0; n < 40; n++) begin
            idx   = 8 + $urandom_range(0, 3);
            rpc   = 14'($urandom);
            rpc[3:0] = 4'(idx);
            is_sm = ($urandom_range(0, 1) == 1);
            len   = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
            uns   = 32'($urandom_range(0, 6000));
            off   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 6000));

            exp_q.delete();
            exp_err = 0;
            if (is_sm) begin
                if (m_valid[idx]) exp_err = 1;
                else begin
                    m_valid[idx] = 1'b1; m_len[idx] = len; m_sent[idx] = '0;
                    m_gr[idx] = (uns < len) ? uns : len;
                end
            end else begin
                if (!m_valid[idx]) exp_err = 1;
                else begin
                    clip = (off < m_len[idx]) ? off : m_len[idx];
                    if (clip > m_gr[idx]) m_gr[idx] = clip;
                end
            end
            if (m_valid[idx]) begin
                add_chunks(14'(idx), m_sent[idx], m_gr[idx]);
                m_sent[idx] = m_gr[idx];
                if (m_sent[idx] == m_len[idx]) m_valid[idx] = 1'b0;
            end

            base = pkt_q.size(); ebase = err_cnt;
            if (is_sm) push_sendmsg(rpc, len, uns);
            else       push_grant(rpc, off);
            wait_pkts(base + exp_q.size(), 16 * exp_q.size() + 40);

            n_cmp++;
            if (pkt_q.size() - base != exp_q.size() || err_cnt - ebase != exp_err) begin
                n_fail++;
                $display("FAIL rand%0d_count: %s rpc=%0d pkts=%0d err=%0d want pkts=%0d err=%0d",
                         n, is_sm ? "sendmsg" : "grant", idx, pkt_q.size() - base,
                         err_cnt - ebase, exp_q.size(), exp_err);
            end
            foreach (exp_q[i]) if (base + i < pkt_q.size()) begin
                n_cmp++;
                if (pkt_q[base+i].rpc !== exp_q[i].rpc || pkt_q[base+i].off !== exp_q[i].off
                    || pkt_q[base+i].len !== exp_q[i].len) begin
                    n_fail++;
                    $display("FAIL rand%0d_pkt%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", n, i,
                             pkt_q[base+i].rpc, pkt_q[base+i].off, pkt_q[base+i].len,
                             exp_q[i].rpc, exp_q[i].off, exp_q[i].len);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unscheduled();
        test_grant_release();
        test_clamp();
        test_backpressure();
        test_arbitration();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
